// File: rtl/phase_calibration_stream_if.sv
// Bundles the phase stream and the offset-table load stream of phase_calibration_stream.
// master drives phases and calibration words; slave is the calibration block.
interface phase_calibration_stream_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_WIDTH  = 8
);
  logic                                in_valid;
  logic [NUM_CHANNELS*PHASE_WIDTH-1:0] phases_in;
  logic                                bypass;
  logic                                out_valid;
  logic [NUM_CHANNELS*PHASE_WIDTH-1:0] phases_out;
  logic                                calib_start;
  logic                                calib_abort;
  logic                                calib_valid;
  logic [PHASE_WIDTH-1:0]              calib_data;
  logic                                calib_ready;
  logic                                calib_busy;
  logic                                calib_done;

  modport master (
    output in_valid, phases_in, bypass, calib_start, calib_abort, calib_valid, calib_data,
    input  out_valid, phases_out, calib_ready, calib_busy, calib_done
  );

  modport slave (
    input  in_valid, phases_in, bypass, calib_start, calib_abort, calib_valid, calib_data,
    output out_valid, phases_out, calib_ready, calib_busy, calib_done
  );
endinterface

// File: rtl/phase_calibration_stream.sv
// Two-stage per-channel phase offset adder with a double-buffered offset table.
// A streamed load fills the shadow table; one COMMIT cycle copies it to the active table.
module phase_calibration_stream #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_WIDTH  = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  phase_calibration_stream_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(NUM_CHANNELS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 v1_q, v1_d;
  logic                 out_valid_q, out_valid_d;
  logic                 word_accept;
  logic                 commit_now;
  logic                 ready_o, busy_o, done_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Abort wins over a same-cycle word; start and abort are ignored outside their state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.calib_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.calib_abort) begin
          state_d = IDLE;
        end else if (bus.calib_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are forced low while reset is held, even before the reset edge.
  always_comb begin
    word_accept = (state_q == LOAD) && bus.calib_valid && !bus.calib_abort;
    commit_now  = (state_q == COMMIT);
    ready_o     = rst_n && (state_q == LOAD);
    busy_o      = rst_n && (state_q != IDLE);
    done_o      = rst_n && (state_q == COMMIT);
  end

  assign bus.calib_ready = ready_o;
  assign bus.calib_busy  = busy_o;
  assign bus.calib_done  = done_o;

  always_comb begin
    v1_d        = bus.in_valid;
    out_valid_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic [PHASE_WIDTH-1:0] in_word;
    logic [PHASE_WIDTH-1:0] shadow_q, shadow_d;
    logic [PHASE_WIDTH-1:0] active_q, active_d;
    logic [PHASE_WIDTH-1:0] s1_q, s1_d;
    logic [PHASE_WIDTH-1:0] po_q, po_d;

    assign in_word = bus.phases_in[gi*PHASE_WIDTH +: PHASE_WIDTH];

    // Stage 1 reads active_q, so the COMMIT-exit sample still sees the old table.
    always_comb begin
      shadow_d = shadow_q;
      if (word_accept && (cnt_q == IDX_WIDTH'(gi))) shadow_d = bus.calib_data;
      active_d = active_q;
      if (commit_now) active_d = shadow_q;
      s1_d = s1_q;
      if (bus.in_valid) s1_d = bus.bypass ? in_word : in_word + active_q;
      po_d = po_q;
      if (v1_q) po_d = s1_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        shadow_q <= '0;
        active_q <= '0;
        s1_q     <= '0;
        po_q     <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
        s1_q     <= s1_d;
        po_q     <= po_d;
      end
    end

    assign bus.phases_out[gi*PHASE_WIDTH +: PHASE_WIDTH] = po_q;
  end
endmodule

// File: tb/tb_phase_calibration_stream.sv
// Randomized and directed checks of phase_calibration_stream against a cycle-level
// behavioural model built from the table-load and offset rules.
module tb_phase_calibration_stream;
  localparam int NC = 4;
  localparam int PW = 8;
  localparam int VW = NC * PW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phase_calibration_stream_if #(.NUM_CHANNELS(NC), .PHASE_WIDTH(PW)) bus ();

  phase_calibration_stream #(.NUM_CHANNELS(NC), .PHASE_WIDTH(PW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit            v;
    logic [VW-1:0] d;
  } samp_t;

  logic [PW-1:0] m_active [NC];
  logic [PW-1:0] m_shadow [NC];
  bit            m_loading, m_committing;
  int            m_words;
  samp_t         pipe[$];
  logic          exp_ov, exp_rdy, exp_busy, exp_done;
  logic [VW-1:0] exp_po;
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic set_idle();
    bus.in_valid    = 1'b0;
    bus.phases_in   = '0;
    bus.bypass      = 1'b0;
    bus.calib_start = 1'b0;
    bus.calib_abort = 1'b0;
    bus.calib_valid = 1'b0;
    bus.calib_data  = '0;
  endtask

  // Advance one clock; the model consumes the inputs the DUT sees at that edge.
  task automatic tick();
    samp_t e;
    e.v = bus.in_valid;
    e.d = '0;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        m_active[i] = '0;
        m_shadow[i] = '0;
      end
      m_loading = 0;
      m_committing = 0;
      m_words = 0;
      pipe.delete();
      exp_po = '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        logic [PW-1:0] lane;
        lane = bus.phases_in[i*PW +: PW];
        e.d[i*PW +: PW] = bus.bypass ? lane : PW'(lane + m_active[i]);
      end
      pipe.push_back(e);
      if (m_committing) begin
        m_active = m_shadow;
        m_committing = 0;
      end else if (m_loading) begin
        if (bus.calib_abort) begin
          m_loading = 0;
        end else if (bus.calib_valid) begin
          m_shadow[m_words] = bus.calib_data;
          m_words++;
          if (m_words == NC) begin
            m_loading = 0;
            m_committing = 1;
          end
        end
      end else if (bus.calib_start) begin
        m_loading = 1;
        m_words = 0;
      end
    end
    @(posedge clk);
    #1;
    exp_rdy  = m_loading;
    exp_busy = m_loading || m_committing;
    exp_done = m_committing;
    exp_ov   = 1'b0;
    if (pipe.size() >= 2) begin
      exp_ov = pipe[pipe.size()-2].v;
      if (pipe[pipe.size()-2].v) exp_po = pipe[pipe.size()-2].d;
    end
    while (pipe.size() > 2) void'(pipe.pop_front());
  endtask

  task automatic load_table(input logic [VW-1:0] words);
    bus.calib_start = 1'b1;
    tick();
    bus.calib_start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      bus.calib_valid = 1'b1;
      bus.calib_data  = words[i*PW +: PW];
      tick();
    end
    bus.calib_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    set_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid    = 1'b1;
    bus.phases_in   = VW'($urandom);
    bus.calib_start = 1'b1;
    bus.calib_valid = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.phases_out !== '0) begin n_bad++; $display("FAIL reset_phases_out got %h want 0", bus.phases_out); end
    n_vec++; if (bus.calib_ready !== 1'b0) begin n_bad++; $display("FAIL reset_calib_ready got %b want 0", bus.calib_ready); end
    n_vec++; if (bus.calib_busy !== 1'b0) begin n_bad++; $display("FAIL reset_calib_busy got %b want 0", bus.calib_busy); end
    n_vec++; if (bus.calib_done !== 1'b0) begin n_bad++; $display("FAIL reset_calib_done got %b want 0", bus.calib_done); end
    rst_n = 1'b1;
    set_idle();
    tick();
  endtask

  task automatic test_passthrough();
    bus.in_valid  = 1'b1;
    bus.phases_in = 32'h04030201;
    tick();
    bus.in_valid  = 1'b0;
    bus.phases_in = 32'hFFFFFFFF;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pass_latency1 out_valid got %b want 0", bus.out_valid); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL pass_latency2 out_valid got %b want 1", bus.out_valid); end
    n_vec++; if (bus.phases_out !== 32'h04030201) begin n_bad++; $display("FAIL pass_data got %h want 04030201", bus.phases_out); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pass_drop out_valid got %b want 0", bus.out_valid); end
    n_vec++; if (bus.phases_out !== 32'h04030201) begin n_bad++; $display("FAIL pass_hold got %h want 04030201", bus.phases_out); end
  endtask

  task automatic test_load();
    logic [PW-1:0] words [NC];
    words = '{8'h01, 8'h02, 8'h03, 8'h04};
    bus.calib_start = 1'b1;
    tick();
    bus.calib_start = 1'b0;
    n_vec++; if (bus.calib_ready !== 1'b1 || bus.calib_busy !== 1'b1) begin n_bad++; $display("FAIL load_enter ready/busy got %b%b want 11", bus.calib_ready, bus.calib_busy); end
    for (int i = 0; i < NC; i++) begin
      bus.calib_valid = 1'b1;
      bus.calib_data  = words[i];
      tick();
      if (i == 0) begin
        bus.calib_valid = 1'b0;
        bus.calib_data  = 8'hEE;
        tick();
      end
      n_vec++;
      if (bus.calib_ready !== exp_rdy || bus.calib_busy !== exp_busy || bus.calib_done !== exp_done) begin
        n_bad++;
        $display("FAIL load_word%0d rdy/busy/done got %b%b%b want %b%b%b", i, bus.calib_ready, bus.calib_busy, bus.calib_done, exp_rdy, exp_busy, exp_done);
      end
    end
    bus.calib_valid = 1'b0;
    n_vec++; if (bus.calib_done !== 1'b1 || bus.calib_ready !== 1'b0) begin n_bad++; $display("FAIL load_commit done/ready got %b%b want 10", bus.calib_done, bus.calib_ready); end
    bus.in_valid  = 1'b1;
    bus.phases_in = 32'h04030201;
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.calib_done !== 1'b0 || bus.calib_busy !== 1'b0) begin n_bad++; $display("FAIL load_exit done/busy got %b%b want 00", bus.calib_done, bus.calib_busy); end
    tick();
    bus.in_valid  = 1'b1;
    bus.phases_in = 32'h04030201;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_vec++; if (bus.out_valid !== 1'b1 || bus.phases_out !== 32'h08060402) begin n_bad++; $display("FAIL load_apply got %b/%h want 1/08060402", bus.out_valid, bus.phases_out); end
  endtask

  task automatic test_wrap();
    bus.in_valid  = 1'b1;
    bus.phases_in = 32'hFEFEFEFE;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_vec++; if (bus.phases_out !== 32'h020100FF) begin n_bad++; $display("FAIL wrap got %h want 020100FF", bus.phases_out); end
  endtask

  task automatic test_abort();
    bus.calib_start = 1'b1;
    tick();
    bus.calib_start = 1'b0;
    bus.calib_valid = 1'b1;
    bus.calib_data  = 8'h10;
    tick();
    tick();
    bus.calib_abort = 1'b1;
    bus.calib_data  = 8'h55;
    tick();
    bus.calib_abort = 1'b0;
    bus.calib_valid = 1'b0;
    n_vec++; if (bus.calib_busy !== 1'b0 || bus.calib_ready !== 1'b0 || bus.calib_done !== 1'b0) begin n_bad++; $display("FAIL abort_idle busy/ready/done got %b%b%b want 000", bus.calib_busy, bus.calib_ready, bus.calib_done); end
    tick();
    n_vec++; if (bus.calib_done !== 1'b0) begin n_bad++; $display("FAIL abort_nodone got %b want 0", bus.calib_done); end
    bus.in_valid  = 1'b1;
    bus.phases_in = '0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_vec++; if (bus.phases_out !== 32'h04030201) begin n_bad++; $display("FAIL abort_table got %h want 04030201", bus.phases_out); end
  endtask

  task automatic test_back_to_back_bypass();
    bus.in_valid  = 1'b1;
    bus.bypass    = 1'b1;
    bus.phases_in = 32'hDDCCBBAA;
    tick();
    bus.in_valid = 1'b0;
    bus.bypass   = 1'b0;
    tick();
    n_vec++; if (bus.phases_out !== 32'hDDCCBBAA) begin n_bad++; $display("FAIL bypass got %h want DDCCBBAA", bus.phases_out); end
    for (int k = 0; k < 12; k++) begin
      bus.in_valid  = 1'b1;
      bus.bypass    = k[0];
      bus.phases_in = VW'($urandom);
      tick();
      n_vec++;
      if (bus.out_valid !== exp_ov || bus.phases_out !== exp_po) begin
        n_bad++;
        $display("FAIL b2b_%0d got %b/%h want %b/%h", k, bus.out_valid, bus.phases_out, exp_ov, exp_po);
      end
    end
    bus.in_valid = 1'b0;
    bus.bypass   = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_commit_boundary();
    logic [PW-1:0] ones [NC];
    do_reset();
    ones = '{8'h01, 8'h01, 8'h01, 8'h01};
    bus.in_valid    = 1'b1;
    bus.calib_start = 1'b1;
    bus.phases_in   = 32'h30303030;
    tick();
    bus.calib_start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      bus.calib_valid = 1'b1;
      bus.calib_data  = ones[i];
      bus.phases_in   = {4{8'(8'h31 + i)}};
      tick();
      n_vec++;
      if (bus.out_valid !== exp_ov || bus.phases_out !== exp_po) begin
        n_bad++;
        $display("FAIL commit_stream_%0d got %b/%h want %b/%h", i, bus.out_valid, bus.phases_out, exp_ov, exp_po);
      end
    end
    bus.calib_valid = 1'b0;
    bus.phases_in   = 32'h40404040;
    tick();
    bus.phases_in = 32'h50505050;
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.phases_out !== 32'h40404040) begin n_bad++; $display("FAIL commit_edge_old got %h want 40404040", bus.phases_out); end
    tick();
    n_vec++; if (bus.phases_out !== 32'h51515151) begin n_bad++; $display("FAIL commit_next_new got %h want 51515151", bus.phases_out); end

    bus.calib_start = 1'b1;
    tick();
    bus.calib_start = 1'b0;
    bus.calib_valid = 1'b1;
    bus.calib_data  = 8'h77;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.calib_ready !== 1'b0 || bus.calib_busy !== 1'b0) begin n_bad++; $display("FAIL midload_reset ready/busy got %b%b want 00", bus.calib_ready, bus.calib_busy); end
    tick();
    rst_n = 1'b1;
    set_idle();
    bus.in_valid  = 1'b1;
    bus.phases_in = 32'h12345678;
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.calib_busy !== 1'b0) begin n_bad++; $display("FAIL midload_idle busy got %b want 0", bus.calib_busy); end
    tick();
    n_vec++; if (bus.phases_out !== 32'h12345678) begin n_bad++; $display("FAIL midload_table got %h want 12345678", bus.phases_out); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst_n           = ($urandom_range(99) != 0);
      bus.in_valid    = $urandom_range(3) != 0;
      bus.phases_in   = VW'($urandom);
      bus.bypass      = $urandom_range(3) == 0;
      bus.calib_start = $urandom_range(9) == 0;
      bus.calib_abort = $urandom_range(29) == 0;
      bus.calib_valid = $urandom_range(9) < 6;
      bus.calib_data  = PW'($urandom);
      tick();
      n_vec++;
      if (bus.out_valid !== exp_ov || bus.phases_out !== exp_po || bus.calib_ready !== exp_rdy ||
          bus.calib_busy !== exp_busy || bus.calib_done !== exp_done) begin
        n_bad++;
        $display("FAIL random_%0d got ov=%b po=%h rdy=%b busy=%b done=%b want ov=%b po=%h rdy=%b busy=%b done=%b",
                 k, bus.out_valid, bus.phases_out, bus.calib_ready, bus.calib_busy, bus.calib_done,
                 exp_ov, exp_po, exp_rdy, exp_busy, exp_done);
      end
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_passthrough();
    test_load();
    test_wrap();
    test_abort();
    test_back_to_back_bypass();
    test_commit_boundary();
    test_random();
    load_table(32'h0A0B0C0D);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/phase_calibration_stream.md
PHASE_CALIBRATION_STREAM -- requirements
Module: phase_calibration_stream

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of transducer phase channels (>=2).
REQ-002 SHALL have parameter PHASE_WIDTH, default 8, bits per phase word.
REQ-003 SHALL derive IDX_WIDTH = $clog2(NUM_CHANNELS) internally for the load counter.
REQ-004 SHALL use one clock and a synchronous, active-low reset. Ports are listed below.
- clk  in  1  sole clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  phases_in valid this cycle
- phases_in  in  NUM_CHANNELS x PHASE_WIDTH  uncalibrated phases
- bypass  in  1  1 = pass phases through without offset
- out_valid  out  1  phases_out valid
- phases_out  out  NUM_CHANNELS x PHASE_WIDTH  calibrated phases
- calib_start  in  1  begin streamed load of the offset table
- calib_abort  in  1  discard an in-progress load
- calib_valid  in  1  calib_data valid
- calib_data  in  PHASE_WIDTH  offset word, channel 0 first
- calib_ready  out  1  load accepting words
- calib_busy  out  1  load in progress (LOAD or COMMIT)
- calib_done  out  1  one-cycle pulse, new table committed

Function
REQ-005 SHALL hold two tables: active (used by datapath) and shadow (load target), each NUM_CHANNELS x PHASE_WIDTH.
REQ-006 SHALL implement FSM IDLE, LOAD, COMMIT; reset state IDLE.
REQ-007 IDLE: calib_start=1 -> LOAD, word counter <= 0; otherwise stay.
REQ-008 LOAD: calib_ready=1; word accepted when calib_valid && calib_ready; accepted word written to shadow[counter], counter increments.
REQ-009 LOAD: accepting word with counter == NUM_CHANNELS-1 -> COMMIT; gaps in calib_valid SHALL stall without timeout.
REQ-010 LOAD: calib_abort=1 -> IDLE, takes priority over a same-cycle calib_valid; word not written, active table unchanged.
REQ-011 calib_start while in LOAD or COMMIT SHALL be ignored; calib_abort in IDLE or COMMIT SHALL be ignored.
REQ-012 COMMIT (exactly one cycle): calib_done=1, calib_ready=0; at the edge leaving COMMIT, active <= shadow and FSM -> IDLE.
REQ-013 calib_busy SHALL be 1 in LOAD and COMMIT, 0 in IDLE; calib_ready SHALL be 1 only in LOAD.
REQ-014 Datapath stage 1: when in_valid=1, s1[i] <= bypass ? phases_in[i] : phases_in[i] + active[i]; v1 <= in_valid every cycle.
REQ-015 Addition SHALL be modulo 2^PHASE_WIDTH (carry discarded), independent per channel.
REQ-016 Stage 2: when v1=1, phases_out <= s1; out_valid <= v1 every cycle; latency in_valid -> out_valid exactly 2 cycles.
REQ-017 Stage data registers SHALL hold their value when their valid input is 0.
REQ-018 Datapath SHALL never stall; full throughput, one vector per cycle, independent of FSM state.
REQ-019 Stage-1 samples taken at the COMMIT-exit edge SHALL use the old active table; samples at later edges use the new table.
REQ-020 bypass SHALL be sampled with phases_in in stage 1 and carried with the data; table contents unaffected.

Reset
REQ-021 rst_n=0 at an edge SHALL clear: active and shadow tables to 0, s1 and phases_out to 0, v1 and out_valid to 0, counter to 0, FSM to IDLE.
REQ-022 During reset calib_ready, calib_busy, calib_done SHALL be 0; reset mid-LOAD discards the partial load.
REQ-023 Reset SHALL take priority over all other inputs in the same cycle.

Verification (NUM_CHANNELS=4, PHASE_WIDTH=8)
REQ-024 Reset, in_valid=1 phases_in {01,02,03,04} one cycle -> out_valid=1 two cycles later, phases_out {01,02,03,04}, out_valid=0 the following cycle.
REQ-025 calib_start, stream {01,02,03,04} with one-cycle gap after word 1 -> calib_ready high throughout LOAD, calib_done pulse one cycle after 4th accept; then phases_in {01,02,03,04} -> phases_out {02,04,06,08}.
REQ-026 Table {01,02,03,04}, phases_in {FE,FE,FE,FE} -> phases_out {FF,00,01,02}.
REQ-027 Table {01,02,03,04}, start load, accept {10,10}, assert calib_abort with calib_valid=1 -> IDLE, no calib_done; phases_in {00,00,00,00} -> {01,02,03,04}.
REQ-028 Table {01,02,03,04}, bypass=1, phases_in {AA,BB,CC,DD} -> phases_out {AA,BB,CC,DD}; back-to-back vectors with bypass toggling each cycle yield per-vector correct results.
REQ-029 Continuous in_valid across COMMIT with old table 0, new {01,01,01,01} -> vector sampled at COMMIT-exit edge unoffset, next vector offset by 01; rst_n=0 mid-LOAD -> FSM IDLE, tables all 0.
